// File: rtl/cont4bits_pkg.sv
// Shared definitions for the 4-bit counter, its stimulus generator and its
// on-line monitor.
package cont4bits_pkg;

    localparam int WIDTH = 4;
    localparam int MAX_Q = (1 << WIDTH) - 1;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

endpackage : cont4bits_pkg

// File: rtl/cont4bits_monitor_if.sv
// Observation bus between a 4-bit up-counter and its monitor. The master side
// drives the counter signals; the slave side (the monitor) reports status.
interface cont4bits_monitor_if #(
    parameter int WIDTH  = cont4bits_pkg::WIDTH,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
);

    logic              enable;
    logic [WIDTH-1:0]  Q;
    logic              TC;
    logic              locked;
    logic              err_pulse;
    logic              err_sticky;
    logic [ERR_W-1:0]  err_count;
    logic [WRAP_W-1:0] wrap_count;

    modport master (
        output enable, Q, TC,
        input  locked, err_pulse, err_sticky, err_count, wrap_count
    );

    modport slave (
        input  enable, Q, TC,
        output locked, err_pulse, err_sticky, err_count, wrap_count
    );

endinterface : cont4bits_monitor_if

// File: rtl/cont_sat_counter.sv
// Up-counter that stops at all-ones instead of rolling over.
module cont_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    // NOTE: always_comb assigns every output a default first, so no path leaves
    // count_d unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : cont_sat_counter

// File: rtl/cont4bits_monitor.sv
// On-line checker for a WIDTH-bit up-counter: rebuilds the expected count,
// flags Q/TC violations, and counts errors and valid wrap-arounds.
module cont4bits_monitor #(
    parameter int WIDTH  = cont4bits_pkg::WIDTH,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    cont4bits_monitor_if.slave  mon
);

    import cont4bits_pkg::*;

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_e           state_q;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] q_prev_q;
    logic             en_prev_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic             err_sticky_q;

    logic             q_bad;
    logic             tc_bad;
    logic             mismatch;
    logic             wrap_hit;
    logic [WIDTH-1:0] en_step;

    always_comb begin
        en_step  = WIDTH'(mon.enable);
        tc_bad   = mon.TC != ((mon.Q == MAX_VAL) && mon.enable);
        // Before lock the only legal value is the counter's reset value.
        q_bad    = (state_q == ST_SYNC) ? (mon.Q != '0) : (mon.Q != exp_q);
        mismatch = q_bad | tc_bad;
        // Resynchronising to the observed Q keeps one fault to one error.
        if ((state_q == ST_SYNC) || mismatch) begin
            exp_d = mon.Q + en_step;
        end else begin
            exp_d = exp_q + en_step;
        end
        wrap_hit = en_prev_q && (mon.Q == '0) && (q_prev_q == MAX_VAL) && !q_bad;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            exp_q        <= '0;
            q_prev_q     <= '0;
            en_prev_q    <= 1'b0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    state_q  <= ST_TRACK;
                    locked_q <= 1'b1;
                end
                ST_TRACK: begin
                    state_q  <= ST_TRACK;
                    locked_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_SYNC;
                    locked_q <= 1'b0;
                end
            endcase
            exp_q       <= exp_d;
            q_prev_q    <= mon.Q;
            en_prev_q   <= mon.enable;
            err_pulse_q <= mismatch;
            if (mismatch) begin
                err_sticky_q <= 1'b1;
            end
        end
    end

    cont_sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (mismatch),
        .count_o (mon.err_count)
    );

    cont_sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (wrap_hit),
        .count_o (mon.wrap_count)
    );

    assign mon.locked     = locked_q;
    assign mon.err_pulse  = err_pulse_q;
    assign mon.err_sticky = err_sticky_q;

endmodule : cont4bits_monitor

// File: tb/tb_cont4bits_monitor.sv
// Self-checking bench for cont4bits_monitor: directed table, corner sequences
// and randomized traffic against a behavioural model of the counter contract.
module tb_cont4bits_monitor;

    import cont4bits_pkg::*;

    localparam int ERR_W   = 8;
    localparam int WRAP_W  = 8;
    localparam int SAT_ERR = (1 << ERR_W) - 1;
    localparam int SAT_WRP = (1 << WRAP_W) - 1;
    localparam int MODULUS = 1 << WIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cont4bits_monitor_if #(.WIDTH(WIDTH), .ERR_W(ERR_W), .WRAP_W(WRAP_W)) ifc ();

    cont4bits_monitor #(.WIDTH(WIDTH), .ERR_W(ERR_W), .WRAP_W(WRAP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        int q;
        bit tc;
        bit pulse;
        int errs;
        int wraps;
    } vec_t;

    vec_t tbl[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: what a checker of the counter contract must report.
    bit m_synced, m_prev_en, m_pulse, m_sticky;
    int m_exp, m_prev_q, m_errs, m_wraps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_synced = 0; m_prev_en = 0; m_pulse = 0; m_sticky = 0;
        m_exp = 0; m_prev_q = 0; m_errs = 0; m_wraps = 0;
    endtask

    task automatic model_edge(input bit en, input int q, input bit tc);
        bit tc_ok, q_ok;
        tc_ok   = (tc == ((q == MAX_Q) && en));
        q_ok    = m_synced ? (q == m_exp) : (q == 0);
        m_pulse = !(q_ok && tc_ok);
        if (m_pulse) begin
            m_sticky = 1;
            if (m_errs < SAT_ERR) m_errs++;
        end
        if (m_prev_en && q == 0 && m_prev_q == MAX_Q && q_ok && m_wraps < SAT_WRP) m_wraps++;
        m_exp     = (q + int'(en)) % MODULUS;
        m_synced  = 1;
        m_prev_q  = q;
        m_prev_en = en;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"},     32'(ifc.locked),     32'(m_synced));
        check({tag, ".err_pulse"},  32'(ifc.err_pulse),  32'(m_pulse));
        check({tag, ".err_sticky"}, 32'(ifc.err_sticky), 32'(m_sticky));
        check({tag, ".err_count"},  32'(ifc.err_count),  32'(m_errs));
        check({tag, ".wrap_count"}, 32'(ifc.wrap_count), 32'(m_wraps));
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input bit en, input int q, input bit tc, input string tag);
        ifc.enable = en;
        ifc.Q      = WIDTH'(q);
        ifc.TC     = tc;
        @(posedge clk);
        model_edge(en, q, tc);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        ifc.enable = 1'b0;
        ifc.Q      = '0;
        ifc.TC     = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input bit en, input int q, input bit tc,
                        input bit pulse, input int errs, input int wraps);
        vec_t v;
        v.en = en; v.q = q; v.tc = tc; v.pulse = pulse; v.errs = errs; v.wraps = wraps;
        tbl.push_back(v);
    endtask

    initial begin
        int cnt;

        // Glitch on Q, then TC violations at max with enable low and high.
        push(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) push(1, i, 0, 0, 0, 0);
        push(1, 5, 0, 1, 1, 0);
        for (int i = 6; i <= 14; i++) push(1, i, 0, 0, 1, 0);
        push(0, 15, 1, 1, 2, 0);
        push(1, 15, 0, 1, 3, 0);
        push(1, 0, 0, 0, 3, 1);
        push(1, 1, 0, 0, 3, 1);

        ifc.enable = 1'b0;
        ifc.Q      = '0;
        ifc.TC     = 1'b0;
        @(negedge clk);

        // Reset held for three cycles, release with enable low and Q at zero.
        do_reset(3);
        step(0, 0, 0, "first_edge");
        check("lock_after_first_edge", 32'(ifc.locked), 32'd1);

        // Correct counter for 40 edges: two full wraps plus eight.
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, cnt, cnt == MAX_Q, "count40");
            cnt = (cnt + 1) % MODULUS;
        end
        check("count40_wraps",  32'(ifc.wrap_count), 32'd2);
        check("count40_errs",   32'(ifc.err_count),  32'd0);
        check("count40_sticky", 32'(ifc.err_sticky), 32'd0);

        // Directed table.
        do_reset(1);
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].q, tbl[i].tc, "table");
            check("tbl_pulse", 32'(ifc.err_pulse),  32'(tbl[i].pulse));
            check("tbl_errs",  32'(ifc.err_count),  32'(tbl[i].errs));
            check("tbl_wraps", 32'(ifc.wrap_count), 32'(tbl[i].wraps));
        end

        // Reset asserted between edges at Q=9 aborts immediately.
        do_reset(1);
        for (int i = 0; i <= 9; i++) step(1, i, 0, "pre_abort");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("mid_reset");
        check("mid_reset_locked", 32'(ifc.locked), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1, i, 0, "resume");
        check("resume_errs", 32'(ifc.err_count), 32'd0);

        // 300 consecutive errors saturate the error counter.
        do_reset(1);
        for (int i = 0; i < 300; i++) step(0, (i % 2) ? 3 : 5, 0, "err_sat");
        check("err_sat_count",  32'(ifc.err_count),  32'(SAT_ERR));
        check("err_sat_sticky", 32'(ifc.err_sticky), 32'd1);

        // 260 clean wraps saturate the wrap counter.
        do_reset(1);
        cnt = 0;
        for (int i = 0; i < 260 * MODULUS + 1; i++) begin
            step(1, cnt, cnt == MAX_Q, "wrap_sat");
            cnt = (cnt + 1) % MODULUS;
        end
        check("wrap_sat_count", 32'(ifc.wrap_count), 32'(SAT_WRP));
        check("wrap_sat_errs",  32'(ifc.err_count),  32'd0);

        // Randomized traffic with occasional Q and TC corruption.
        do_reset(1);
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            bit en, tc;
            int q;
            en = ($urandom_range(0, 3) != 0);
            q  = cnt;
            if ($urandom_range(0, 19) == 0) q = q ^ int'($urandom_range(1, MAX_Q));
            tc = (q == MAX_Q) && en;
            if ($urandom_range(0, 24) == 0) tc = !tc;
            step(en, q, tc, "random");
            if (en) cnt = (cnt + 1) % MODULUS;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_cont4bits_monitor
